lmsm_seq: RTL and testbench
===========================

LMSM_SEQ -- requirements
Module: lmsm_seq

Interface
REQ-001 The block SHALL have the following ports: clk, input, 1, single clock, all state updates on rising edge.
REQ-002 The block SHALL have the following port: proc_rst, input, 1, asynchronous active-high reset.
REQ-003 The block SHALL have the following port: start, input, 1, begin a multi-register transfer (sampled only while busy=0).
REQ-004 The block SHALL have the following port: is_store, input, 1, 1=store-multiple (RF->mem), 0=load-multiple (mem->RF), latched on accepted start.
REQ-005 The block SHALL have the following port: base_addr, input, 16, first memory address, latched on accepted start.
REQ-006 The block SHALL have the following port: reg_mask, input, 8, bit i set = transfer register Ri, latched on accepted start.
REQ-007 The block SHALL have the following port: mem_ready, input, 1, memory completes the current request this cycle.
REQ-008 The block SHALL have the following port: busy, output, 1, high in XFER and DONE.
REQ-009 The block SHALL have the following port: done, output, 1, one-cycle completion pulse.
REQ-010 The block SHALL have the following port: rf_addr, output, 3, register index for the current transfer (RF read port for store, RF write address for load).
REQ-011 The block SHALL have the following port: rf_wen, output, 1, RF write enable (load only).
REQ-012 The block SHALL have the following port: mem_addr, output, 16, current memory address.
REQ-013 The block SHALL have the following ports: mem_read and mem_write, outputs, 1 each, memory request strobes.
REQ-014 The block SHALL have the following port: xfer_count, output, 4, number of completed transfers in the current or last operation (0..8).

Function
REQ-015 The block SHALL implement the states IDLE, XFER and DONE.
REQ-016 In IDLE, start=1 SHALL latch is_store, base_addr and reg_mask, clear xfer_count, and go to XFER, or go directly to DONE if reg_mask=0.
REQ-017 In XFER, rf_addr SHALL equal the index of the lowest set bit of the remaining mask (ascending order R0 first), and mem_addr SHALL equal the current address register.
REQ-018 In XFER, mem_read SHALL be !is_store and mem_write SHALL be is_store; both SHALL be 0 in IDLE and DONE.
REQ-019 The request SHALL be held with address, rf_addr and strobes stable while mem_ready=0, for any number of cycles.
REQ-020 On an XFER cycle with mem_ready=1, the block SHALL clear that mask bit, increment the address by 1 (16-bit wrap, 0xFFFF->0x0000) and increment xfer_count.
REQ-021 On that same cycle, the block SHALL go to DONE if the remaining mask becomes zero, and otherwise stay in XFER.
REQ-022 rf_wen SHALL equal XFER & mem_ready & !is_store, combinationally in the completing cycle; all other outputs SHALL be decoded from registered state only.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE; xfer_count SHALL hold its value until the next accepted start.
REQ-024 start while busy=1 SHALL be ignored, and input changes after acceptance SHALL have no effect.
REQ-025 Latency with mem_ready tied high SHALL be as follows: for N set mask bits, done asserts N+1 cycles after the start edge (1 cycle for mask=0).

Reset
REQ-026 proc_rst=1 SHALL immediately force IDLE, the latched mask to 0, the address to 0 and xfer_count to 0, giving busy=0, done=0, mem_read=0, mem_write=0, rf_wen=0, rf_addr=0 and mem_addr=0.
REQ-027 Reset asserted mid-transfer SHALL abort without a done pulse, and no strobe SHALL be asserted in the cycle after reset deasserts.

Structure
REQ-028 The state encoding, address width (16), register-count constant (8) and count width SHALL reside in shared package lmsm_pkg.
REQ-029 The lowest-set-bit priority encoder (8-bit in, 3-bit index out) SHALL be the single sub-module lowbit_enc.

Verification
REQ-030 The bench SHALL cover the following scenario: LM, base=0x0040, mask=0x05, mem_ready=1 -> (rf_addr,mem_addr) = (0,0x0040) then (2,0x0041), rf_wen pulses twice, done at cycle 3, xfer_count=2.
REQ-031 The bench SHALL cover the following scenario: SM, mask=0xFF, base=0xFFFE, mem_ready=1 -> mem_write for 8 cycles, addresses 0xFFFE, 0xFFFF, 0x0000..0x0005, rf_wen never high, xfer_count=8.
REQ-032 The bench SHALL cover the following scenario: mask=0x00 start -> done at cycle 1, no strobes, xfer_count=0.
REQ-033 The bench SHALL cover the following scenario: LM mask=0x80 with mem_ready low for 3 cycles -> mem_read held with rf_addr=7 for 4 cycles, a single rf_wen in the ready cycle, done next cycle.
REQ-034 The bench SHALL cover the following scenario: a second start during busy with different mask -> ignored, original sequence completes unchanged.
REQ-035 The bench SHALL cover the following scenario: proc_rst asserted during the third transfer of mask=0x1F -> all outputs 0 at once, no done, IDLE accepts a new start afterwards.

Source files
------------

// File: rtl/lmsm_pkg.sv
// lmsm_pkg: shared types and sizes for the load/store-multiple sequencer
package lmsm_pkg;
  localparam int AW = 16;
  localparam int NREG = 8;
  localparam int CW = 4;
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;
endpackage

// File: rtl/lmsm_seq_lowbit_enc.sv
// lowbit_enc: index of the lowest set bit of an 8-bit mask (0 when mask is empty)
module lowbit_enc
  import lmsm_pkg::*;
(
  input  logic [NREG-1:0] mask,
  output logic [2:0]      idx
);
  always_comb begin
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) idx = mask[i] ? 3'(i) : idx;
  end
endmodule

// File: rtl/lmsm_seq.sv
// lmsm_seq: sequences a multi-register load/store, one register per accepted memory cycle
module lmsm_seq
  import lmsm_pkg::*;
(
  input  logic          clk,
  input  logic          proc_rst,
  input  logic          start,
  input  logic          is_store,
  input  logic [AW-1:0] base_addr,
  input  logic [7:0]    reg_mask,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done,
  output logic [2:0]    rf_addr,
  output logic          rf_wen,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [CW-1:0] xfer_count
);
  state_t state;
  logic st;
  logic [AW-1:0] addr;
  logic [NREG-1:0] mask, rest;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  lowbit_enc u_enc (.mask(mask), .idx(idx));
  assign rest = mask & ~(NREG'(1) << idx);
  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      state <= S_IDLE;
      st <= 1'b0;
      addr <= '0;
      mask <= '0;
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          st <= is_store;
          addr <= base_addr;
          mask <= reg_mask;
          cnt <= '0;
          state <= (reg_mask == '0) ? S_DONE : S_XFER;
        end
        S_XFER: if (mem_ready) begin
          mask <= rest;
          addr <= addr + 1'b1;
          cnt <= cnt + 1'b1;
          state <= (rest == '0) ? S_DONE : S_XFER;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  // Mask is zero outside a transfer, so the encoder naturally yields rf_addr=0 there
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign rf_addr = idx;
  assign mem_addr = addr;
  assign mem_read = (state == S_XFER) & ~st;
  assign mem_write = (state == S_XFER) & st;
  assign rf_wen = (state == S_XFER) & mem_ready & ~st;
  assign xfer_count = cnt;
endmodule

// File: tb/tb_lmsm_seq.sv
// tb_lmsm_seq: directed and random load/store-multiple operations against a list-based model
module tb_lmsm_seq;
  logic clk = 1'b0;
  logic proc_rst, start, is_store, mem_ready;
  logic [15:0] base_addr, mem_addr;
  logic [7:0] reg_mask;
  logic busy, done, rf_wen, mem_read, mem_write;
  logic [2:0] rf_addr;
  logic [3:0] xfer_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lmsm_seq dut (
    .clk(clk), .proc_rst(proc_rst), .start(start), .is_store(is_store),
    .base_addr(base_addr), .reg_mask(reg_mask), .mem_ready(mem_ready),
    .busy(busy), .done(done), .rf_addr(rf_addr), .rf_wen(rf_wen),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .xfer_count(xfer_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {11'b0, busy, done, mem_read, mem_write, rf_wen}, 16'h0);
    chk({tag, "_rf_addr"}, {13'b0, rf_addr}, 16'h0);
    chk({tag, "_mem_addr"}, mem_addr, 16'h0);
    chk({tag, "_count"}, {12'b0, xfer_count}, 16'h0);
  endtask

  // stall<0 picks a random wait per transfer; abort_at>=0 resets during that transfer
  task automatic run_op(input logic s, input logic [15:0] base, input logic [7:0] m,
                        input int stall, input int abort_at);
    int regs[$];
    int n;
    for (int i = 0; i < 8; i++) if (m[i]) regs.push_back(i);
    n = regs.size();
    @(negedge clk);
    start = 1'b1; is_store = s; base_addr = base; reg_mask = m; mem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; is_store = ~s; base_addr = 16'($urandom); reg_mask = 8'($urandom);
    for (int k = 0; k < n; k++) begin
      int w;
      w = stall < 0 ? int'($urandom_range(0, 2)) : stall;
      for (int c = 0; c <= w; c++) begin
        @(negedge clk);
        mem_ready = (c == w);
        start = 1'($urandom_range(0, 1));
        reg_mask = 8'($urandom);
        if (k == abort_at) begin
          proc_rst = 1'b1;
          #1 chk_zero("rst_now");
          start = 1'b0;
          @(posedge clk);
          @(negedge clk);
          proc_rst = 1'b0;
          #1 chk_zero("rst_release");
          @(posedge clk);
          @(negedge clk);
          #1 chk_zero("rst_after");
          return;
        end
        #1;
        chk("busy", {15'b0, busy}, 16'h1);
        chk("done", {15'b0, done}, 16'h0);
        chk("rf_addr", {13'b0, rf_addr}, 16'(regs[k]));
        chk("mem_addr", mem_addr, base + 16'(k));
        chk("mem_read", {15'b0, mem_read}, {15'b0, ~s});
        chk("mem_write", {15'b0, mem_write}, {15'b0, s});
        chk("rf_wen", {15'b0, rf_wen}, {15'b0, (c == w) && !s});
        chk("xfer_count", {12'b0, xfer_count}, 16'(k));
        @(posedge clk);
      end
    end
    @(negedge clk);
    mem_ready = 1'($urandom_range(0, 1));
    start = 1'($urandom_range(0, 1));
    #1;
    chk("done_pulse", {14'b0, busy, done}, 16'h3);
    chk("done_strobes", {13'b0, mem_read, mem_write, rf_wen}, 16'h0);
    chk("done_count", {12'b0, xfer_count}, 16'(n));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("idle_ctl", {11'b0, busy, done, mem_read, mem_write, rf_wen}, 16'h0);
    chk("idle_count", {12'b0, xfer_count}, 16'(n));
  endtask

  initial begin
    proc_rst = 1'b1; start = 1'b0; is_store = 1'b0; mem_ready = 1'b0;
    base_addr = 16'h0; reg_mask = 8'h0;
    #2 chk_zero("reset");
    @(negedge clk);
    proc_rst = 1'b0;
    run_op(1'b0, 16'h0040, 8'h05, 0, -1);
    run_op(1'b1, 16'hFFFE, 8'hFF, 0, -1);
    run_op(1'b0, 16'h1234, 8'h00, 0, -1);
    run_op(1'b0, 16'h0100, 8'h80, 3, -1);
    run_op(1'b0, 16'h0200, 8'h1F, 0, 2);
    run_op(1'b1, 16'h0300, 8'h0A, 1, -1);
    for (int t = 0; t < 24; t++)
      run_op(1'($urandom_range(0, 1)), 16'($urandom),
             (t % 6 == 0) ? 8'h00 : 8'($urandom), -1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
